alarm_ring_ctrl: RTL and testbench
==================================

ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 Parameter RING_CYCLES, default 600: clock cycles a ring lasts before auto-stop.
REQ-002 Parameter BEEP_HALF, default 5: clock cycles per BUZZ half-period while ringing.
REQ-003 Parameter SNOOZE_MIN, default 5: snooze offset in minutes (used only with ALM_SNOOZE_EN).
REQ-004 CLK  in  1  system clock; all logic on rising edge.
REQ-005 RST  in  1  synchronous, active-low reset.
REQ-006 ALM_HOUR  in  1  alarm-hour edit mode from alarm control.
REQ-007 ALM_MIN  in  1  alarm-minute edit mode from alarm control.
REQ-008 ALM_ONOFF  in  1  alarm enable from alarm control.
REQ-009 SW_INC  in  1  increment button, level, already debounced.
REQ-010 SW_STOP  in  1  stop/snooze button, level, already debounced.
REQ-011 CUR_HOUR  in  5  current hour, binary 0-23.
REQ-012 CUR_MIN  in  6  current minute, binary 0-59.
REQ-013 CUR_SEC  in  6  current second, binary 0-59.
REQ-014 ALM_H_OUT  out  5  stored alarm hour, binary 0-23.
REQ-015 ALM_M_OUT  out  6  stored alarm minute, binary 0-59.
REQ-016 BUZZ  out  1  buzzer drive, registered.
REQ-017 RINGING  out  1  high while state is RING, registered.

Function
REQ-018 SW_INC, SW_STOP SHALL be edge-detected with a registered previous value; an action fires once, on the cycle after each 0->1 transition.
REQ-019 SW_INC edge with ALM_HOUR=1 increments alarm hour, 23 wraps to 0; with ALM_MIN=1 (ALM_HOUR=0) increments alarm minute, 59 wraps to 0; hour has priority if both high; no change if neither.
REQ-020 Alarm time editing SHALL work in every state and never alters current state.
REQ-021 States IDLE, ARMED, RING, SNOOZE; ALM_ONOFF=0 forces IDLE next cycle from any state, highest priority.
REQ-022 IDLE -> ARMED when ALM_ONOFF=1.
REQ-023 Match = (CUR_HOUR==ALM_H_OUT && CUR_MIN==ALM_M_OUT && CUR_SEC==0); only the 0->1 edge of registered match is a trigger, so a held match never retriggers.
REQ-024 ARMED + trigger -> RING; RINGING and BUZZ go high on the clock edge after the trigger cycle.
REQ-025 In RING, BUZZ starts high and toggles every BEEP_HALF cycles; BUZZ=0 in all other states.
REQ-026 RING -> ARMED after RING_CYCLES cycles in RING, or on SW_STOP edge (SNOOZE instead when ALM_SNOOZE_EN defined); SW_STOP edge outside RING/SNOOZE is ignored.
REQ-027 Ring counter SHALL clear on every entry to RING.

Reset
REQ-028 RST=0 at a clock edge: state IDLE, ALM_H_OUT=0, ALM_M_OUT=0, BUZZ=0, RINGING=0, counters and edge registers 0; applies mid-ring too.
REQ-029 First trigger after reset requires a fresh 0->1 match edge.

Configuration
REQ-030 Macro ALM_SNOOZE_EN defined: SW_STOP edge in RING -> SNOOZE; snooze target = alarm time + SNOOZE_MIN minutes, minute wrap carries into hour, 23:59 wraps to 00:xx; SNOOZE -> RING on match edge against snooze target; SW_STOP edge in SNOOZE -> ARMED; RING timeout -> ARMED.
REQ-031 Macro undefined: no SNOOZE state or snooze target logic; SW_STOP edge in RING -> ARMED.

Verification
REQ-032 Reset, ALM_HOUR=1, 3 SW_INC pulses -> ALM_H_OUT=3; ALM_MIN=1, 2 pulses -> ALM_M_OUT=2.
REQ-033 ALM_H_OUT=23, one SW_INC with ALM_HOUR=1 -> 0; ALM_M_OUT=59, one with ALM_MIN=1 -> 0; SW_INC held high 20 cycles -> single increment.
REQ-034 Alarm 07:30, ALM_ONOFF=1, time 07:30:00 -> RINGING=1 next cycle, BUZZ 5 high/5 low, RINGING=0 after 600 cycles, no retrigger while CUR_SEC stays 0.
REQ-035 Ringing, SW_STOP pulse -> RINGING=0 and BUZZ=0 within 2 cycles; ALM_ONOFF=0 mid-ring -> IDLE, BUZZ=0 next cycle.
REQ-036 ALM_SNOOZE_EN, alarm 23:58: stop at 23:58 -> SNOOZE, time 00:03:00 -> RING again; second ring timeout -> ARMED.
REQ-037 RST=0 mid-ring -> BUZZ=0, RINGING=0, ALM_H_OUT=0, ALM_M_OUT=0 after that edge.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: alarm-time editing, match-edge triggered ring with beeping buzzer.
// Optional snooze support is enabled by defining the macro ALM_SNOOZE_EN.
module alarm_ring_ctrl #(
    parameter int RING_CYCLES = 600,
    parameter int BEEP_HALF   = 5,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ALM_HOUR,
    input  logic       ALM_MIN,
    input  logic       ALM_ONOFF,
    input  logic       SW_INC,
    input  logic       SW_STOP,
    input  logic [4:0] CUR_HOUR,
    input  logic [5:0] CUR_MIN,
    input  logic [5:0] CUR_SEC,
    output logic [4:0] ALM_H_OUT,
    output logic [5:0] ALM_M_OUT,
    output logic       BUZZ,
    output logic       RINGING
);

`ifdef ALM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, ARMED, RING, SNOOZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ARMED, RING} state_t;
`endif

    localparam int RC_W = $clog2(RING_CYCLES + 1);
    localparam int BH_W = $clog2(BEEP_HALF + 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_CYCLES - 1);
    localparam logic [BH_W-1:0] BEEP_LAST = BH_W'(BEEP_HALF - 1);

    state_t            state_q, state_d;
    logic [4:0]        alm_h_q, alm_h_d;
    logic [5:0]        alm_m_q, alm_m_d;
    logic              inc_prev_q, inc_prev_d;
    logic              stop_prev_q, stop_prev_d;
    logic              alm_match_q, alm_match_d;
    logic              alm_match_prev_q, alm_match_prev_d;
    logic [RC_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [BH_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic              buzz_q, buzz_d;
    logic              ringing_q, ringing_d;

    logic inc_edge, stop_edge, alm_trig, enter_ring;

`ifdef ALM_SNOOZE_EN
    logic       snz_match_q, snz_match_d;
    logic       snz_match_prev_q, snz_match_prev_d;
    logic       snz_trig;
    logic [4:0] snz_h;
    logic [5:0] snz_m;
    logic [6:0] snz_m_sum;

    // Snooze target is the alarm time pushed forward, with minute carry into the hour.
    always_comb begin
        snz_m_sum = {1'b0, alm_m_q} + 7'(SNOOZE_MIN);
        snz_h     = alm_h_q;
        snz_m     = snz_m_sum[5:0];
        if (snz_m_sum >= 7'd60) begin
            snz_m = 6'(snz_m_sum - 7'd60);
            snz_h = (alm_h_q == 5'd23) ? 5'd0 : alm_h_q + 5'd1;
        end
        snz_match_d      = (CUR_HOUR == snz_h) && (CUR_MIN == snz_m) && (CUR_SEC == 6'd0);
        snz_match_prev_d = snz_match_q;
        snz_trig         = snz_match_q & ~snz_match_prev_q;
    end
`endif

    always_comb begin
        inc_prev_d       = SW_INC;
        stop_prev_d      = SW_STOP;
        inc_edge         = SW_INC & ~inc_prev_q;
        stop_edge        = SW_STOP & ~stop_prev_q;

        alm_h_d = alm_h_q;
        alm_m_d = alm_m_q;
        if (inc_edge) begin
            if (ALM_HOUR) begin
                alm_h_d = (alm_h_q == 5'd23) ? 5'd0 : alm_h_q + 5'd1;
            end else if (ALM_MIN) begin
                alm_m_d = (alm_m_q == 6'd59) ? 6'd0 : alm_m_q + 6'd1;
            end
        end

        // Only the rising edge of the registered match triggers, so a held match is ignored.
        alm_match_d      = (CUR_HOUR == alm_h_q) && (CUR_MIN == alm_m_q) && (CUR_SEC == 6'd0);
        alm_match_prev_d = alm_match_q;
        alm_trig         = alm_match_q & ~alm_match_prev_q;

        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        beep_cnt_d = beep_cnt_q;
        buzz_d     = 1'b0;
        enter_ring = 1'b0;

        if (!ALM_ONOFF) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = ARMED;
                ARMED: enter_ring = alm_trig;
                RING: begin
                    if (stop_edge) begin
`ifdef ALM_SNOOZE_EN
                        state_d = SNOOZE;
`else
                        state_d = ARMED;
`endif
                    end else if (ring_cnt_q == RING_LAST) begin
                        state_d = ARMED;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RC_W'(1);
                        if (beep_cnt_q == BEEP_LAST) begin
                            beep_cnt_d = '0;
                            buzz_d     = ~buzz_q;
                        end else begin
                            beep_cnt_d = beep_cnt_q + BH_W'(1);
                            buzz_d     = buzz_q;
                        end
                    end
                end
`ifdef ALM_SNOOZE_EN
                SNOOZE: begin
                    if (stop_edge) begin
                        state_d = ARMED;
                    end else begin
                        enter_ring = snz_trig;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        if (enter_ring) begin
            state_d    = RING;
            ring_cnt_d = '0;
            beep_cnt_d = '0;
            buzz_d     = 1'b1;
        end

        ringing_d = (state_d == RING);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q          <= IDLE;
            alm_h_q          <= '0;
            alm_m_q          <= '0;
            inc_prev_q       <= 1'b0;
            stop_prev_q      <= 1'b0;
            alm_match_q      <= 1'b0;
            alm_match_prev_q <= 1'b0;
            ring_cnt_q       <= '0;
            beep_cnt_q       <= '0;
            buzz_q           <= 1'b0;
            ringing_q        <= 1'b0;
`ifdef ALM_SNOOZE_EN
            snz_match_q      <= 1'b0;
            snz_match_prev_q <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            alm_h_q          <= alm_h_d;
            alm_m_q          <= alm_m_d;
            inc_prev_q       <= inc_prev_d;
            stop_prev_q      <= stop_prev_d;
            alm_match_q      <= alm_match_d;
            alm_match_prev_q <= alm_match_prev_d;
            ring_cnt_q       <= ring_cnt_d;
            beep_cnt_q       <= beep_cnt_d;
            buzz_q           <= buzz_d;
            ringing_q        <= ringing_d;
`ifdef ALM_SNOOZE_EN
            snz_match_q      <= snz_match_d;
            snz_match_prev_q <= snz_match_prev_d;
`endif
        end
    end

    assign ALM_H_OUT = alm_h_q;
    assign ALM_M_OUT = alm_m_q;
    assign BUZZ      = buzz_q;
    assign RINGING   = ringing_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed self-checking bench for alarm_ring_ctrl (default parameters).
module tb_alarm_ring_ctrl;

    logic       clk;
    logic       rst_n;
    logic       alm_hour, alm_min, alm_onoff, sw_inc, sw_stop;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [4:0] alm_h_out;
    logic [5:0] alm_m_out;
    logic       buzz, ringing;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    alarm_ring_ctrl dut (
        .CLK(clk), .RST(rst_n), .ALM_HOUR(alm_hour), .ALM_MIN(alm_min),
        .ALM_ONOFF(alm_onoff), .SW_INC(sw_inc), .SW_STOP(sw_stop),
        .CUR_HOUR(cur_hour), .CUR_MIN(cur_min), .CUR_SEC(cur_sec),
        .ALM_H_OUT(alm_h_out), .ALM_M_OUT(alm_m_out), .BUZZ(buzz), .RINGING(ringing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            sw_inc = 1'b1; tick(1);
            sw_inc = 1'b0; tick(1);
        end
    endtask

    task automatic pulse_stop();
        sw_stop = 1'b1; tick(1);
        sw_stop = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    // Move off the match second, then onto the given time, and wait for the ring to start.
    task automatic trigger_at(input int h, input int m, output bit seen);
        cur_sec = 6'd1;
        tick(2);
        set_time(h, m, 0);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick(1);
            if (ringing === 1'b1) seen = 1'b1;
        end
    endtask

    bit seen;
    bit retrig;

    initial begin
        rst_n = 1'b0; alm_hour = 0; alm_min = 0; alm_onoff = 0; sw_inc = 0; sw_stop = 0;
        set_time(12, 0, 30);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_h", 32'(alm_h_out), 0);
        check("rst_m", 32'(alm_m_out), 0);
        check("rst_buzz", 32'(buzz), 0);
        check("rst_ringing", 32'(ringing), 0);

        alm_hour = 1; pulse_inc(3);
        check("hour_inc3", 32'(alm_h_out), 3);
        alm_hour = 0; alm_min = 1; pulse_inc(2);
        check("min_inc2", 32'(alm_m_out), 2);
        alm_hour = 1; pulse_inc(1);
        check("both_hour", 32'(alm_h_out), 4);
        check("both_min", 32'(alm_m_out), 2);
        alm_hour = 0; alm_min = 0; pulse_inc(1);
        check("none_hour", 32'(alm_h_out), 4);
        check("none_min", 32'(alm_m_out), 2);

        alm_hour = 1; pulse_inc(19);
        check("hour_23", 32'(alm_h_out), 23);
        pulse_inc(1);
        check("hour_wrap", 32'(alm_h_out), 0);
        alm_hour = 0; alm_min = 1; pulse_inc(57);
        check("min_59", 32'(alm_m_out), 59);
        pulse_inc(1);
        check("min_wrap", 32'(alm_m_out), 0);

        sw_inc = 1; tick(20); sw_inc = 0; tick(1);
        check("held_inc", 32'(alm_m_out), 1);

        pulse_inc(29);
        alm_min = 0; alm_hour = 1; pulse_inc(7);
        alm_hour = 0;
        check("set_0730_h", 32'(alm_h_out), 7);
        check("set_0730_m", 32'(alm_m_out), 30);

        alm_onoff = 1; tick(2);
        check("armed_quiet", 32'(ringing), 0);
        trigger_at(7, 30, seen);
        check("ring_start", 32'(seen), 1);
        // Expected beep pattern: 5 high, 5 low, repeated.
        for (int i = 0; i < 20; i++) exp_q.push_back(32'(((i / 5) % 2) == 0));
        for (int i = 0; i < 20; i++) begin
            check($sformatf("buzz_%0d", i), 32'(buzz), exp_q.pop_front());
            tick(1);
        end
        tick(579);
        check("ring_last_cycle", 32'(ringing), 1);
        tick(1);
        check("ring_timeout", 32'(ringing), 0);
        check("timeout_buzz", 32'(buzz), 0);
        retrig = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ringing) retrig = 1;
        end
        check("no_retrigger", 32'(retrig), 0);

        trigger_at(7, 30, seen);
        check("ring_again", 32'(seen), 1);
        tick(3);
        pulse_stop();
        tick(1);
        check("stop_ringing", 32'(ringing), 0);
        check("stop_buzz", 32'(buzz), 0);

        alm_onoff = 0; tick(1); alm_onoff = 1; tick(2);
        // Stop press while armed must not disturb the next trigger.
        pulse_stop();
        tick(2);
        trigger_at(7, 30, seen);
        check("ring_after_idle_stop", 32'(seen), 1);
        tick(4);
        alm_onoff = 0; tick(1);
        check("off_ringing", 32'(ringing), 0);
        check("off_buzz", 32'(buzz), 0);
        check("off_keep_h", 32'(alm_h_out), 7);
        check("off_keep_m", 32'(alm_m_out), 30);

        alm_onoff = 1; tick(2);
        trigger_at(7, 30, seen);
        check("ring_pre_reset", 32'(seen), 1);
        tick(2);
        rst_n = 1'b0; tick(1);
        check("midring_rst_buzz", 32'(buzz), 0);
        check("midring_rst_ringing", 32'(ringing), 0);
        check("midring_rst_h", 32'(alm_h_out), 0);
        check("midring_rst_m", 32'(alm_m_out), 0);
        rst_n = 1'b1;
        alm_onoff = 0;
        tick(2);

`ifdef ALM_SNOOZE_EN
        alm_hour = 1; pulse_inc(23);
        alm_hour = 0; alm_min = 1; pulse_inc(58);
        alm_min = 0;
        check("set_2358_h", 32'(alm_h_out), 23);
        check("set_2358_m", 32'(alm_m_out), 58);
        alm_onoff = 1; tick(2);
        trigger_at(23, 58, seen);
        check("snz_ring1", 32'(seen), 1);
        tick(3);
        pulse_stop();
        tick(1);
        check("snz_stopped", 32'(ringing), 0);
        trigger_at(0, 3, seen);
        check("snz_ring2", 32'(seen), 1);
        tick(600);
        check("snz_timeout", 32'(ringing), 0);
        trigger_at(23, 58, seen);
        check("snz_back_armed", 32'(seen), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
